// File: rtl/bp_cfg_link_loader.sv
// Byte-link to cfg-bus bridge: deserializes write/read commands from the link, issues one
// cfg transaction at a time and serializes the response back on the same link.
module bp_cfg_link_loader #(
  parameter int link_width_p     = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [link_width_p-1:0]     link_data_i,
  input  logic                        link_v_i,
  output logic                        link_ready_o,
  output logic [link_width_p-1:0]     link_data_o,
  output logic                        link_v_o,
  input  logic                        link_ready_i,
  output logic                        cfg_v_o,
  output logic                        cfg_w_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  input  logic [cfg_data_width_p-1:0] cfg_rdata_i,
  input  logic                        cfg_rdata_v_i,
  output logic                        err_o
);

  // state | meaning
  // IDLE  | waiting for an opcode flit
  // ADDR  | collecting address flits, LSB first
  // DATA  | collecting write data flits, LSB first
  // ISSUE | cfg request presented until cfg_ready_i
  // RWAIT | read accepted, waiting for cfg_rdata_v_i
  // RESP  | streaming response flits back on the link

  localparam int addr_flits_lp = cfg_addr_width_p / link_width_p;
  localparam int data_flits_lp = cfg_data_width_p / link_width_p;
  localparam int max_flits_lp  = (addr_flits_lp > data_flits_lp) ? addr_flits_lp : data_flits_lp;
  localparam int cnt_width_lp  = $clog2(max_flits_lp + 1);

  localparam logic [cnt_width_lp-1:0] addr_last_lp = cnt_width_lp'(addr_flits_lp - 1);
  localparam logic [cnt_width_lp-1:0] data_last_lp = cnt_width_lp'(data_flits_lp - 1);
  localparam logic [link_width_p-1:0] op_write_lp  = link_width_p'(8'h01);
  localparam logic [link_width_p-1:0] op_read_lp   = link_width_p'(8'h02);

  if ((cfg_addr_width_p % link_width_p) != 0) begin : g_bad_addr_width
    $error("cfg_addr_width_p must be an integer multiple of link_width_p");
  end
  if ((cfg_data_width_p % link_width_p) != 0) begin : g_bad_data_width
    $error("cfg_data_width_p must be an integer multiple of link_width_p");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ISSUE,
    ST_RWAIT,
    ST_RESP
  } state_e;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [cnt_width_lp-1:0]     r_cnt;
  logic                        w_cnt_inc;
  logic                        r_is_write;
  logic [cfg_addr_width_p-1:0] r_addr;
  logic [cfg_data_width_p-1:0] r_data;
  logic [cfg_data_width_p-1:0] r_rdata;
  logic                        r_err;
  logic                        w_opc_legal;
  logic [cnt_width_lp-1:0]     w_resp_last;

  assign w_opc_legal = (link_data_i == op_write_lp) || (link_data_i == op_read_lp);
  assign w_resp_last = r_is_write ? '0 : data_last_lp;

  assign cfg_w_o    = r_is_write;
  assign cfg_addr_o = r_addr;
  assign cfg_data_o = r_data;
  assign err_o      = r_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // link_ready_o depends on state only, so there is no combinational path from link_v_i.
  always_comb begin
    w_state_nxt  = r_state;
    link_ready_o = 1'b0;
    link_v_o     = 1'b0;
    cfg_v_o      = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        link_ready_o = 1'b1;
        if (link_v_i && w_opc_legal) begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        link_ready_o = 1'b1;
        if (link_v_i) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == addr_last_lp) begin
            w_state_nxt = r_is_write ? ST_DATA : ST_ISSUE;
          end
        end
      end
      ST_DATA: begin
        link_ready_o = 1'b1;
        if (link_v_i) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == data_last_lp) begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cfg_v_o = 1'b1;
        if (cfg_ready_i) begin
          w_state_nxt = r_is_write ? ST_RESP : ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (cfg_rdata_v_i) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        link_v_o = 1'b1;
        if (link_ready_i) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == w_resp_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    link_data_o = '0;
    if (r_state == ST_RESP) begin
      for (int i = 0; i < data_flits_lp; i++) begin
        if (r_cnt == cnt_width_lp'(i)) begin
          link_data_o = r_rdata[i*link_width_p +: link_width_p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= (r_state == ST_IDLE) && link_v_i && !w_opc_legal;

      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + cnt_width_lp'(1);
      end

      if ((r_state == ST_IDLE) && link_v_i && w_opc_legal) begin
        r_is_write <= (link_data_i == op_write_lp);
      end

      if ((r_state == ST_ADDR) && link_v_i) begin
        for (int i = 0; i < addr_flits_lp; i++) begin
          if (r_cnt == cnt_width_lp'(i)) begin
            r_addr[i*link_width_p +: link_width_p] <= link_data_i;
          end
        end
      end

      if ((r_state == ST_DATA) && link_v_i) begin
        for (int i = 0; i < data_flits_lp; i++) begin
          if (r_cnt == cnt_width_lp'(i)) begin
            r_data[i*link_width_p +: link_width_p] <= link_data_i;
          end
        end
      end

      // The write acknowledge reuses the response shifter as a single-flit payload.
      if ((r_state == ST_ISSUE) && cfg_ready_i && r_is_write) begin
        r_rdata <= cfg_data_width_p'(op_write_lp);
      end
      if ((r_state == ST_RWAIT) && cfg_rdata_v_i) begin
        r_rdata <= cfg_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_bp_cfg_link_loader.sv
// Scoreboard bench for bp_cfg_link_loader: expected cfg requests and response flits are
// queued as packets are driven and popped when the DUT presents them.
module tb_bp_cfg_link_loader;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [7:0]  link_data_i = '0;
  logic        link_v_i = 1'b0;
  logic        link_ready_o;
  logic [7:0]  link_data_o;
  logic        link_v_o;
  logic        link_ready_i;
  logic        cfg_v_o;
  logic        cfg_w_o;
  logic [15:0] cfg_addr_o;
  logic [63:0] cfg_data_o;
  logic        cfg_ready_i;
  logic [63:0] cfg_rdata_i;
  logic        cfg_rdata_v_i;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  bp_cfg_link_loader #(
    .link_width_p    (8),
    .cfg_addr_width_p(16),
    .cfg_data_width_p(64)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .link_data_i  (link_data_i),
    .link_v_i     (link_v_i),
    .link_ready_o (link_ready_o),
    .link_data_o  (link_data_o),
    .link_v_o     (link_v_o),
    .link_ready_i (link_ready_i),
    .cfg_v_o      (cfg_v_o),
    .cfg_w_o      (cfg_w_o),
    .cfg_addr_o   (cfg_addr_o),
    .cfg_data_o   (cfg_data_o),
    .cfg_ready_i  (cfg_ready_i),
    .cfg_rdata_i  (cfg_rdata_i),
    .cfg_rdata_v_i(cfg_rdata_v_i),
    .err_o        (err_o)
  );

  typedef struct {
    logic        w;
    logic [15:0] addr;
    logic [63:0] data;
  } cfg_exp_t;

  cfg_exp_t   cfg_q[$];
  logic [7:0] resp_q[$];

  logic [7:0] p_wr[$] = '{8'h01, 8'h34, 8'h12, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] p_rd[$] = '{8'h02, 8'h10, 8'h00};
  logic [7:0] p_rd2[$] = '{8'h02, 8'h03, 8'h02};
  logic [7:0] r_rd[$] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] r_rd2[$] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = -100;
  int last_event_cyc = -100;
  int last_resp_cyc = -100;
  int n_cfg = 0;
  int n_resp = 0;
  int n_err_pulses = 0;

  int          cfg_stall = 0;
  bit          resp_toggle = 1'b0;
  logic [63:0] rd_value = '0;
  int          rd_req_cnt = 0;
  int          spur_req = 0;
  bit          rd_real = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // cfg target and response sink
  initial begin
    int stall_cnt = 0;
    int rd_seen = 0;
    int rd_delay = 0;
    int spur_seen = 0;
    cfg_ready_i = 1'b0;
    link_ready_i = 1'b0;
    cfg_rdata_v_i = 1'b0;
    cfg_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      cfg_rdata_v_i = 1'b0;
      rd_real = 1'b0;
      if (cfg_v_o) begin
        if (stall_cnt < cfg_stall) begin
          cfg_ready_i = 1'b0;
          stall_cnt++;
        end else begin
          cfg_ready_i = 1'b1;
        end
      end else begin
        cfg_ready_i = 1'b0;
        stall_cnt = 0;
      end
      link_ready_i = resp_toggle ? ~link_ready_i : 1'b1;
      if (rd_req_cnt != rd_seen) begin
        rd_seen = rd_req_cnt;
        rd_delay = 3;
      end else if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) begin
          cfg_rdata_v_i = 1'b1;
          cfg_rdata_i = rd_value;
          rd_real = 1'b1;
        end
      end else if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        cfg_rdata_v_i = 1'b1;
        cfg_rdata_i = 64'h5A5A_5A5A_A5A5_A5A5;
      end
    end
  end

  // output monitor
  initial begin
    logic        prev_cfg_v = 1'b0, prev_link_v = 1'b0, prev_err = 1'b0;
    logic        prev_cfg_hold = 1'b0, prev_resp_hold = 1'b0;
    logic        prev_w = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [63:0] prev_data = '0;
    logic [7:0]  prev_ldata = '0;
    cfg_exp_t    e;
    logic [7:0]  ef;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        prev_cfg_v = 1'b0;
        prev_link_v = 1'b0;
        prev_err = 1'b0;
        prev_cfg_hold = 1'b0;
        prev_resp_hold = 1'b0;
      end else begin
        if (cfg_v_o && !prev_cfg_v) chk("cfg_latency", 64'(cyc - acc_cyc), 64'd1);
        if (prev_cfg_hold && cfg_v_o) begin
          chk("cfg_hold_w", cfg_w_o, prev_w);
          chk("cfg_hold_addr", cfg_addr_o, prev_addr);
          chk("cfg_hold_data", cfg_data_o, prev_data);
        end
        if (cfg_v_o && cfg_ready_i) begin
          n_cfg++;
          chk("cfg_expected", cfg_q.size() > 0, 1'b1);
          if (cfg_q.size() > 0) begin
            e = cfg_q.pop_front();
            chk("cfg_w", cfg_w_o, e.w);
            chk("cfg_addr", cfg_addr_o, e.addr);
            if (e.w) chk("cfg_data", cfg_data_o, e.data);
          end
          if (cfg_w_o) last_event_cyc = cyc;
          else rd_req_cnt++;
        end
        if (cfg_rdata_v_i && rd_real) last_event_cyc = cyc;
        if (link_v_o && !prev_link_v) chk("resp_latency", 64'(cyc - last_event_cyc), 64'd1);
        if (prev_resp_hold && link_v_o) chk("resp_hold", link_data_o, prev_ldata);
        if (link_v_o && link_ready_i) begin
          n_resp++;
          last_resp_cyc = cyc;
          chk("resp_expected", resp_q.size() > 0, 1'b1);
          if (resp_q.size() > 0) begin
            ef = resp_q.pop_front();
            chk("resp_data", link_data_o, ef);
          end
        end
        if (cfg_v_o || link_v_o) chk("busy_link_ready", link_ready_o, 1'b0);
        if (err_o) begin
          n_err_pulses++;
          chk("err_single", prev_err, 1'b0);
        end
        prev_cfg_v = cfg_v_o;
        prev_link_v = link_v_o;
        prev_err = err_o;
        prev_cfg_hold = cfg_v_o && !cfg_ready_i;
        prev_resp_hold = link_v_o && !link_ready_i;
        prev_w = cfg_w_o;
        prev_addr = cfg_addr_o;
        prev_data = cfg_data_o;
        prev_ldata = link_data_o;
      end
    end
  end

  task automatic send_flit(input logic [7:0] d, output int acc);
    int t = 0;
    link_data_i = d;
    link_v_i = 1'b1;
    do begin
      @(negedge clk_i);
      t++;
    end while (!link_ready_o && t < 300);
    chk("in_accept_timeout", t < 300, 1'b1);
    acc = cyc;
    acc_cyc = cyc;
    @(posedge clk_i);
    #1;
    link_v_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] f[$], input int max_gap, output int opc_cyc);
    int a;
    opc_cyc = -1;
    for (int i = 0; i < f.size(); i++) begin
      send_flit(f[i], a);
      if (i == 0) opc_cyc = a;
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
  endtask

  task automatic push_write();
    cfg_q.push_back('{1'b1, 16'h1234, 64'h1122_3344_5566_7788});
    resp_q.push_back(8'h01);
  endtask

  task automatic push_read(input logic [15:0] a, input logic [7:0] r[$]);
    cfg_q.push_back('{1'b0, a, 64'h0});
    foreach (r[i]) resp_q.push_back(r[i]);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((cfg_q.size() != 0 || resp_q.size() != 0) && t < 3000) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    chk("drain_timeout", t < 3000, 1'b1);
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_link_ready"}, link_ready_o, 1'b1);
    chk({tag, "_cfg_v"}, cfg_v_o, 1'b0);
    chk({tag, "_link_v"}, link_v_o, 1'b0);
    chk({tag, "_err"}, err_o, 1'b0);
    chk({tag, "_link_data"}, link_data_o, 8'h00);
    chk({tag, "_cfg_w"}, cfg_w_o, 1'b0);
    chk({tag, "_cfg_addr"}, cfg_addr_o, 16'h0);
    chk({tag, "_cfg_data"}, cfg_data_o, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int opc;
    int a;
    int err_base;
    int cfg_base;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // write followed immediately by a read (back-to-back)
    push_write();
    send_pkt(p_wr, 0, opc);
    rd_value = 64'hDEAD_BEEF_CAFE_F00D;
    push_read(16'h0010, r_rd);
    send_pkt(p_rd, 0, opc);
    chk("b2b_opcode_cycle", 64'(opc - last_resp_cyc), 64'd1);
    wait_done();

    // cfg and link backpressure
    cfg_stall = 5;
    resp_toggle = 1'b1;
    rd_value = 64'h0123_4567_89AB_CDEF;
    push_read(16'h0203, r_rd2);
    send_pkt(p_rd2, 0, opc);
    wait_done();
    cfg_stall = 0;
    resp_toggle = 1'b0;

    // illegal opcode then a normal write
    err_base = n_err_pulses;
    cfg_base = n_cfg;
    send_flit(8'h7F, a);
    chk("err_next_cycle", err_o, 1'b1);
    push_write();
    send_pkt(p_wr, 0, opc);
    wait_done();
    chk("err_pulses", 64'(n_err_pulses - err_base), 64'd1);
    chk("cfg_after_illegal", 64'(n_cfg - cfg_base), 64'd1);

    // stray read data while idle must be ignored
    spur_req++;
    repeat (4) begin
      @(posedge clk_i);
      #1;
      chk("spur_link_v", link_v_o, 1'b0);
    end
    chk("spur_link_ready", link_ready_o, 1'b1);

    // write with random gaps between flits
    push_write();
    send_pkt(p_wr, 3, opc);
    wait_done();

    // reset mid-packet, then a full read
    cfg_base = n_cfg;
    for (int i = 0; i < 5; i++) send_flit(p_wr[i], a);
    reset_n_i = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk_i);
    #1;
    chk("midreset_held_cfg_v", cfg_v_o, 1'b0);
    reset_n_i = 1'b1;
    rd_value = 64'hDEAD_BEEF_CAFE_F00D;
    push_read(16'h0010, r_rd);
    send_pkt(p_rd, 0, opc);
    wait_done();
    chk("cfg_after_reset", 64'(n_cfg - cfg_base), 64'd1);

    chk("total_cfg", 64'(n_cfg), 64'd6);
    chk("total_resp", 64'(n_resp), 64'd27);
    chk("total_err", 64'(n_err_pulses), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
